// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 5-digit BCD converter
//
// Converts a BIN_W-bit binary count into five BCD digits, one input bit per
// clock, for the frequency meter's 7-segment display driver. The digit
// outputs change only on the FINISH edge, so the display never shows a
// partially converted value.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   start        in   1      conversion request, accepted only while busy=0
//   bin          in   BIN_W  binary value, sampled on the accept edge
//   busy         out  1      conversion in progress (SHIFT or FINISH)
//   done         out  1      one-cycle pulse: digits/ovf just updated
//   TenThousand  out  4      BCD ten-thousands digit
//   Thousand     out  4      BCD thousands digit
//   Hundred      out  4      BCD hundreds digit
//   Ten          out  4      BCD tens digit
//   One          out  4      BCD ones digit
//   ovf          out  1      value >= 100000; digits then hold bin mod 100000
module bin2bcd_seq #(
  parameter int BIN_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       TenThousand,
  output logic [3:0]       Thousand,
  output logic [3:0]       Hundred,
  output logic [3:0]       Ten,
  output logic [3:0]       One,
  output logic             ovf
);

  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [19:0]      scratch;
  logic [19:0]      adj;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  assign busy = (state != IDLE);

  // Add-3 correction: any digit >= 5 would exceed 9 once doubled, so bias it
  // so that the following left shift carries correctly into the next digit.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      scratch     <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      TenThousand <= 4'h0;
      Thousand    <= 4'h0;
      Hundred     <= 4'h0;
      Ten         <= 4'h0;
      One         <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // A bit leaving the top corrected digit is worth 100000; dropping it
          // leaves the digits at value mod 100000, and the sticky flag records it.
          scratch <= {adj[18:0], shreg[BIN_W-1]};
          carry   <= carry | adj[19];
          shreg   <= shreg << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1))
            state <= FINISH;
        end
        FINISH: begin
          TenThousand <= scratch[19:16];
          Thousand    <= scratch[15:12];
          Hundred     <= scratch[11:8];
          Ten         <= scratch[7:4];
          One         <= scratch[3:0];
          ovf         <= carry;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [16:0] bin = '0;
  logic        busy, done, ovf;
  logic [3:0]  d4, d3, d2, d1, d0;
  logic [19:0] digits;

  int errors = 0;
  int checks = 0;

  assign digits = {d4, d3, d2, d1, d0};

  bin2bcd_seq #(.BIN_W(17)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done),
    .TenThousand(d4), .Thousand(d3), .Hundred(d2), .Ten(d1), .One(d0),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drive start for exactly one rising edge (the accept edge); returns #1 after it.
  task automatic do_start(input logic [16:0] b);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; lat = -1 when the bound expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, ovf, digits} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b ovf=%b digits=%h want all 0", busy, done, ovf, digits);
    end
    @(negedge clk);
    rst = 1'b0;
    do_start(17'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy got %b want 1", busy);
    end
    wait_done(lat);
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL zero_latency got %0d want 18", lat);
    end
    checks++;
    if (digits !== 20'h00000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero_digits got %h ovf=%b want 00000 ovf=0", digits, ovf);
    end
  endtask

  task automatic test_basic;
    int lat;
    do_start(17'd12345);
    wait_done(lat);
    checks++;
    if (lat != 18) begin
      errors++;
      $display("FAIL basic_latency got %0d want 18", lat);
    end
    checks++;
    if (digits !== 20'h12345 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_digits got %h ovf=%b want 12345 ovf=0", digits, ovf);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_boundaries;
    logic [16:0] vin [3]  = '{17'd99999, 17'd100000, 17'd131071};
    logic [19:0] vexp [3] = '{20'h99999, 20'h00000, 20'h31071};
    logic        vovf [3] = '{1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_start(vin[i]);
      wait_done(lat);
      checks++;
      if (lat != 18 || digits !== vexp[i] || ovf !== vovf[i]) begin
        errors++;
        $display("FAIL boundary_%0d got lat=%0d digits=%h ovf=%b want lat=18 digits=%h ovf=%b",
                 vin[i], lat, digits, ovf, vexp[i], vovf[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    do_start(17'd42);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1;
        bin   = 17'd55555;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 18 || digits !== 20'h00042 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d digits=%h ovf=%b want lat=18 digits=00042 ovf=0", lat, digits, ovf);
    end
    // still inside the done cycle: request the next conversion now
    start = 1'b1;
    bin   = 17'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle_accept got done=%b busy=%b want 0 1", done, busy);
    end
    wait_done(lat);
    checks++;
    if (lat != 18 || digits !== 20'h00007) begin
      errors++;
      $display("FAIL done_cycle_result got lat=%0d digits=%h want lat=18 digits=00007", lat, digits);
    end
  endtask

  task automatic test_reset_mid_conversion;
    int lat;
    bit seen;
    do_start(17'd12345);
    wait_done(lat);
    checks++;
    if (digits !== 20'h12345) begin
      errors++;
      $display("FAIL abort_prior got %h want 12345", digits);
    end
    do_start(17'd678);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checks++;
    if (digits !== 20'h00000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got digits=%h busy=%b done=%b ovf=%b want 00000 0 0 0", digits, busy, done, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done got activity=1 want 0");
    end
    do_start(17'd678);
    wait_done(lat);
    checks++;
    if (lat != 18 || digits !== 20'h00678) begin
      errors++;
      $display("FAIL abort_restart got lat=%0d digits=%h want lat=18 digits=00678", lat, digits);
    end
  endtask

  task automatic test_hold_digits;
    int lat;
    int bad_k;
    do_start(17'd12345);
    wait_done(lat);
    do_start(17'd54321);
    bad_k = 0;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (bad_k == 0 && (digits !== 20'h12345 || busy !== 1'b1 || done !== 1'b0)) bad_k = k;
    end
    checks++;
    if (bad_k != 0) begin
      errors++;
      $display("FAIL hold_during_conv at edge %0d got digits=%h busy=%b done=%b want 12345 1 0", bad_k, digits, busy, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || digits !== 20'h54321 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_finish got done=%b digits=%h busy=%b want 1 54321 0", done, digits, busy);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_boundaries;
    test_start_while_busy;
    test_reset_mid_conversion;
    test_hold_digits;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
